// File: rtl/polar_column_sequencer_if.sv
`default_nettype none
// =============================================================================
// Module   : polar_column_sequencer_if
// Summary  : Frame-memory read port and LED-driver column output bundle.
// Revision : 1.0 - initial release
// =============================================================================
interface polar_column_sequencer_if #(
    parameter int SCAN_RATE    = 32,
    parameter int NUM_ROWS     = 64,
    parameter int RGB_RES      = 9,
    parameter int NUM_CHANNELS = 2
) ();
    localparam int ADDR_W = $clog2(SCAN_RATE);

    logic                                               rd_req;
    logic [ADDR_W-1:0]                                  rd_addr;
    logic                                               rd_valid;
    logic [NUM_ROWS*RGB_RES-1:0]                        rd_data;
    logic [NUM_CHANNELS-1:0][NUM_ROWS-1:0][RGB_RES-1:0] columns;
    logic                                               columns_valid;

    modport master (
        output rd_req,
        output rd_addr,
        input  rd_valid,
        input  rd_data,
        output columns,
        output columns_valid
    );

    modport slave (
        input  rd_req,
        input  rd_addr,
        output rd_valid,
        output rd_data,
        input  columns,
        input  columns_valid
    );
endinterface
`default_nettype wire

// File: rtl/polar_column_sequencer.sv
`default_nettype none
// =============================================================================
// Module   : polar_column_sequencer
// Summary  : Angular slice tracker and per-slice column fetch for a POV rotor.
// Revision : 1.0 - initial release
// =============================================================================
module polar_column_sequencer #(
    parameter int SCAN_RATE    = 32,
    parameter int NUM_ROWS     = 64,
    parameter int RGB_RES      = 9,
    parameter int THETA_RES    = 27,
    parameter int NUM_CHANNELS = 2
) (
    input  wire logic                         clk_in,
    input  wire logic                         rst_in,
    input  wire logic [THETA_RES-1:0]         theta,
    input  wire logic                         period_ready,
    input  wire logic [THETA_RES-1:0]         period,
    input  wire logic                         mode,
    output logic      [$clog2(SCAN_RATE)-1:0] slice,
    output logic                              overrun,
    polar_column_sequencer_if.master          bus
);
    localparam int ADDR_W  = $clog2(SCAN_RATE);
    localparam int SPACING = SCAN_RATE / NUM_CHANNELS;
    localparam int CH_W    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [CH_W-1:0]   LAST_CH    = CH_W'(NUM_CHANNELS - 1);
    localparam logic [ADDR_W-1:0] LAST_SLICE = ADDR_W'(SCAN_RATE - 1);

    typedef logic [NUM_CHANNELS-1:0][NUM_ROWS-1:0][RGB_RES-1:0] col_set_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT   = 2'd2,
        COMMIT = 2'd3
    } state_t;

    // ---------------------------------------------------------------- slice tracker
    logic [THETA_RES-1:0] slice_width;
    logic [THETA_RES:0]   boundary;
    logic                 new_slice;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            slice_width <= '0;
            boundary    <= '0;
            slice       <= '0;
            new_slice   <= 1'b0;
        end else begin
            new_slice <= 1'b0;
            if (period_ready) begin
                slice_width <= period >> ADDR_W;
                boundary    <= {1'b0, period >> ADDR_W};
                slice       <= '0;
                new_slice   <= 1'b1;
            end else if (slice_width != '0 && {1'b0, theta} >= boundary &&
                         slice != LAST_SLICE) begin
                slice     <= slice + 1'b1;
                boundary  <= boundary + {1'b0, slice_width};
                new_slice <= 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------- fetch sequencer
    state_t                                      state;
    logic [CH_W-1:0]                             ch;
    logic [CH_W-1:0]                             next_ch;
    logic [ADDR_W-1:0]                           fetch_slice;
    logic                                        pattern_mode;
    logic                                        pending_valid;
    logic [ADDR_W-1:0]                           pending_slice;
    col_set_t                                    shadow;
    col_set_t                                    col_pattern;
    col_set_t                                    col_data;
    logic                                        col_valid;
    logic                                        req_strobe;
    logic [ADDR_W-1:0]                           req_addr;
    logic [NUM_CHANNELS-1:0][ADDR_W-1:0]         fetch_addr;
    logic                                        launch;
    logic [ADDR_W-1:0]                           launch_slice;

    assign next_ch = ch + 1'b1;

    // Channel addresses wrap naturally by truncation to the address width.
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
        assign fetch_addr[c] = fetch_slice + ADDR_W'(c * SPACING);
        for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
            assign col_pattern[c][r] = RGB_RES'(fetch_addr[c]);
        end
    end

    // A new sequence starts from IDLE, or straight out of COMMIT when a slice
    // arrived during the previous sequence (a same-cycle arrival is the latest).
    always_comb begin
        launch       = 1'b0;
        launch_slice = slice;
        if (state == IDLE) begin
            launch = new_slice;
        end else if (state == COMMIT) begin
            launch = new_slice || pending_valid;
            if (!new_slice) begin
                launch_slice = pending_slice;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state         <= IDLE;
            ch            <= '0;
            fetch_slice   <= '0;
            pattern_mode  <= 1'b0;
            pending_valid <= 1'b0;
            pending_slice <= '0;
            shadow        <= '0;
            col_data      <= '0;
            col_valid     <= 1'b0;
            req_strobe    <= 1'b0;
            req_addr      <= '0;
            overrun       <= 1'b0;
        end else begin
            req_strobe <= 1'b0;
            col_valid  <= 1'b0;

            if (new_slice && state != IDLE) begin
                overrun       <= 1'b1;
                pending_valid <= 1'b1;
                pending_slice <= slice;
            end

            case (state)
                IDLE: begin
                end
                REQ: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (bus.rd_valid) begin
                        shadow[ch] <= bus.rd_data;
                        if (ch == LAST_CH) begin
                            state <= COMMIT;
                        end else begin
                            ch         <= next_ch;
                            req_strobe <= 1'b1;
                            req_addr   <= fetch_addr[next_ch];
                            state      <= REQ;
                        end
                    end
                end
                COMMIT: begin
                    if (pattern_mode) begin
                        col_data <= col_pattern;
                    end else begin
                        col_data <= shadow;
                    end
                    col_valid     <= 1'b1;
                    pending_valid <= 1'b0;
                    if (!launch) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (launch) begin
                fetch_slice  <= launch_slice;
                pattern_mode <= mode;
                ch           <= '0;
                if (mode) begin
                    state <= COMMIT;
                end else begin
                    state      <= REQ;
                    req_strobe <= 1'b1;
                    req_addr   <= launch_slice;
                end
            end
        end
    end

    assign bus.rd_req        = req_strobe;
    assign bus.rd_addr       = req_addr;
    assign bus.columns       = col_data;
    assign bus.columns_valid = col_valid;
endmodule
`default_nettype wire

// File: tb/tb_polar_column_sequencer.sv
`default_nettype none
// =============================================================================
// Module   : tb_polar_column_sequencer
// Summary  : Randomised scoreboard bench for polar_column_sequencer.
// Revision : 1.0 - initial release
// =============================================================================
module tb_polar_column_sequencer;
    localparam int SR   = 32;
    localparam int NR   = 64;
    localparam int RGB  = 9;
    localparam int TR   = 27;
    localparam int NC   = 2;
    localparam int AW   = 5;
    localparam int SPC  = SR / NC;
    localparam int COLW = NR * RGB;

    typedef logic [NC-1:0][COLW-1:0] cols_t;
    typedef struct {
        cols_t cols;
        int    cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [TR-1:0] theta = '0;
    logic [TR-1:0] period = '0;
    logic          period_ready = 1'b0;
    logic          mode = 1'b0;
    logic [AW-1:0] slice;
    logic          overrun;

    polar_column_sequencer_if #(
        .SCAN_RATE(SR), .NUM_ROWS(NR), .RGB_RES(RGB), .NUM_CHANNELS(NC)
    ) bus ();

    polar_column_sequencer #(
        .SCAN_RATE(SR), .NUM_ROWS(NR), .RGB_RES(RGB), .THETA_RES(TR), .NUM_CHANNELS(NC)
    ) dut (
        .clk_in      (clk),
        .rst_in      (rst),
        .theta       (theta),
        .period_ready(period_ready),
        .period      (period),
        .mode        (mode),
        .slice       (slice),
        .overrun     (overrun),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int               total = 0;
    int               bad = 0;
    logic [COLW-1:0]  mem [SR];
    exp_t             exp_q[$];
    int               addr_q[$];
    bit               sb_on = 1'b1;
    int               lat = 1;
    int               ovr_cv = 0;
    int               last_a0 = -1;
    int               prev_slice = 0;

    task automatic check(string nm, longint act, longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    // Expected columns for a sequence started at slice s.
    function automatic cols_t model_cols(int s, bit m);
        cols_t v;
        for (int c = 0; c < NC; c++) begin
            int a;
            a = (s + c * SPC) % SR;
            if (m) begin
                for (int r = 0; r < NR; r++) v[c][r*RGB +: RGB] = RGB'(a);
            end else begin
                v[c] = mem[a];
            end
        end
        return v;
    endfunction

    // Frame memory: answers each read strobe after 'lat' cycles.
    initial begin
        bus.rd_valid = 1'b0;
        bus.rd_data  = '0;
        forever begin
            @(negedge clk);
            if (bus.rd_req === 1'b1) begin
                int a;
                a = int'(bus.rd_addr);
                repeat (lat) @(posedge clk);
                #1 bus.rd_valid = 1'b1;
                bus.rd_data = mem[a];
                @(posedge clk);
                #1 bus.rd_valid = 1'b0;
            end
        end
    end

    // Monitor: read-address and column-commit scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.rd_req === 1'b1 && sb_on) begin
                    total++;
                    if (addr_q.size() == 0) begin
                        bad++;
                        $display("FAIL rd_req unexpected addr=%0d", bus.rd_addr);
                    end else begin
                        int ea;
                        ea = addr_q.pop_front();
                        if (int'(bus.rd_addr) != ea) begin
                            bad++;
                            $display("FAIL rd_addr got=%0d want=%0d", bus.rd_addr, ea);
                        end
                    end
                end
                if (bus.columns_valid === 1'b1) begin
                    cols_t act;
                    act = bus.columns;
                    total++;
                    if (sb_on) begin
                        if (exp_q.size() == 0) begin
                            bad++;
                            $display("FAIL columns_valid unexpected at cyc=%0d", cyc);
                        end else begin
                            exp_t e;
                            e = exp_q.pop_front();
                            if (act !== e.cols) begin
                                bad++;
                                $display("FAIL cols got_ch0=%h want_ch0=%h", act[0][127:0], e.cols[0][127:0]);
                            end
                            total++;
                            if (cyc != e.cyc) begin
                                bad++;
                                $display("FAIL cols_timing got=%0d want=%0d", cyc, e.cyc);
                            end
                        end
                    end else begin
                        int  a0;
                        bit  ok;
                        a0 = int'(act[0][RGB-1:0]);
                        ok = (a0 < SR);
                        if (ok) begin
                            for (int c = 0; c < NC; c++)
                                if (act[c] !== mem[(a0 + c * SPC) % SR]) ok = 1'b0;
                        end
                        if (!ok) begin
                            bad++;
                            $display("FAIL overrun_cols inconsistent got_a0=%0d want=consistent", a0);
                        end
                        ovr_cv++;
                        last_a0 = a0;
                    end
                end
            end
        end
    end

    // One revolution: theta ramps from 0 with period_ready on the first cycle.
    task automatic rev(int p, int len, bit m, int l, bit push);
        int w;
        w = p / SR;
        for (int i = 0; i < len; i++) begin
            bit ev;
            int s;
            int es;
            @(posedge clk);
            #1;
            theta        = TR'(i);
            period_ready = (i == 0);
            period       = TR'(p);
            if (i == 0) begin
                mode = m;
                lat  = l;
            end
            ev = (i == 0) || (w != 0 && (i % w) == 0 && (i / w) <= SR - 1);
            s  = (i == 0 || w == 0) ? 0 : i / w;
            if (ev && push) begin
                exp_t e;
                e.cols = model_cols(s, m);
                e.cyc  = cyc + (m ? 3 : 3 + NC * (l + 1));
                exp_q.push_back(e);
                if (!m) begin
                    for (int c = 0; c < NC; c++) addr_q.push_back((s + c * SPC) % SR);
                end
            end
            @(negedge clk);
            if (i == 0) es = prev_slice;
            else if (w == 0) es = 0;
            else es = ((i - 1) / w > SR - 1) ? SR - 1 : (i - 1) / w;
            check("slice", slice, es);
        end
        prev_slice = (w == 0) ? 0 : (((len - 1) / w > SR - 1) ? SR - 1 : (len - 1) / w);
    endtask

    initial begin
        for (int a = 0; a < SR; a++) begin
            for (int r = 0; r < NR; r++) mem[a][r*RGB +: RGB] = RGB'($urandom);
            mem[a][RGB-1:0] = RGB'(a);
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_columns_zero", (bus.columns == '0), 1);
        check("rst_columns_valid", bus.columns_valid, 0);
        check("rst_rd_req", bus.rd_req, 0);
        check("rst_rd_addr", bus.rd_addr, 0);
        check("rst_slice", slice, 0);
        check("rst_overrun", overrun, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        rev(3200, 3300, 1'b1, 1, 1'b1);
        rev(3200, 3200, 1'b0, 3, 1'b1);
        rev(20, 20, 1'b0, 2, 1'b1);
        rev(20, 20, 1'b1, 1, 1'b1);
        rev(20, 20, 1'b0, 4, 1'b1);
        for (int k = 0; k < 6; k++) begin
            int w;
            int p;
            w = 16 + int'($urandom_range(0, 24));
            p = w * SR + int'($urandom_range(0, SR - 1));
            rev(p, p, 1'($urandom_range(0, 1)), 1 + int'($urandom_range(0, 3)), 1'b1);
        end
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("no_false_overrun", overrun, 0);
        check("queue_drained_pre_overrun", exp_q.size() + addr_q.size(), 0);

        sb_on = 1'b0;
        rev(1600, 1700, 1'b0, 60, 1'b0);
        @(negedge clk);
        check("overrun_set", overrun, 1);
        repeat (400) @(posedge clk);
        @(negedge clk);
        check("overrun_sticky", overrun, 1);
        check("overrun_coalesced", (ovr_cv > 0 && ovr_cv < SR), 1);
        check("overrun_latest_slice", last_a0, SR - 1);

        sb_on = 1'b1;
        exp_q.delete();
        addr_q.delete();
        @(posedge clk);
        #1;
        theta = '0; period_ready = 1'b1; period = TR'(32000); mode = 1'b0; lat = 20;
        addr_q.push_back(0);
        @(posedge clk);
        #1;
        period_ready = 1'b0; theta = TR'(1);
        begin
            int k;
            k = 0;
            while (bus.rd_req !== 1'b1 && k < 10) begin
                @(negedge clk);
                k++;
            end
            check("rd_req_before_reset", bus.rd_req, 1);
        end
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_rst_columns_zero", (bus.columns == '0), 1);
        check("async_rst_columns_valid", bus.columns_valid, 0);
        check("async_rst_rd_req", bus.rd_req, 0);
        check("async_rst_rd_addr", bus.rd_addr, 0);
        check("async_rst_slice", slice, 0);
        check("async_rst_overrun", overrun, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        prev_slice = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1 theta = TR'(i + 2);
            @(negedge clk);
            check("post_rst_slice", slice, 0);
        end

        rev(640, 640, 1'($urandom_range(0, 1)), 2, 1'b1);
        repeat (50) @(posedge clk);
        @(negedge clk);
        check("exp_q_empty", exp_q.size(), 0);
        check("addr_q_empty", addr_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
